// File: rtl/gate_chk_pkg.sv
// Shared types and the reference gate model for gate_resp_checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Slot index width caps the usable CNT_W of the checker.
  localparam int SLOT_IDX_W = 16;

  typedef struct packed {
    logic                  vld;
    logic                  exp;
    logic [SLOT_IDX_W-1:0] idx;
  } slot_t;

  localparam int SLOT_W = $bits(slot_t);

  function automatic logic gate_eval(op_e op, logic a, logic b);
    logic y;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = ~(a & b);
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_resp_checker_exp_delay_line.sv
// exp_delay_line: DEPTH-stage shift register of expectation slots with sync clear.
// o_any_vld flags valid slots still queued behind the output stage.
module exp_delay_line
  import gate_chk_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic [SLOT_W-1:0] i_slot,
  output logic [SLOT_W-1:0] o_slot,
  output logic              o_any_vld
);

  if (DEPTH == 0) begin : g_comb
    logic w_unused_clk;
    assign w_unused_clk = i_clk ^ i_clr;
    assign o_slot       = i_slot;
    assign o_any_vld    = 1'b0;
  end else begin : g_pipe
    slot_t r_slot_p [DEPTH];

    // Only the valid bits are cleared; payload follows whatever is shifted in.
    always_ff @(posedge i_clk) begin
      r_slot_p[0] <= slot_t'(i_slot);
      for (int k = 1; k < DEPTH; k++) begin
        r_slot_p[k] <= r_slot_p[k-1];
      end
      if (i_clr) begin
        for (int k = 0; k < DEPTH; k++) begin
          r_slot_p[k].vld <= 1'b0;
        end
      end
    end

    assign o_slot = r_slot_p[DEPTH-1];

    always_comb begin
      o_any_vld = 1'b0;
      for (int k = 0; k < DEPTH - 1; k++) begin
        o_any_vld = o_any_vld | r_slot_p[k].vld;
      end
    end
  end

endmodule

// File: rtl/gate_resp_checker.sv
// Response checker for 2-input gate DUTs: delays the expected output by DUT_LAT and scores it.
// Optional GATE_CHK_ABORT_EN: end the run on the first mismatch.
module gate_resp_checker
  import gate_chk_pkg::*;
#(
  parameter int N_VEC   = 4,
  parameter int DUT_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic             i_stim_valid,
  input  logic             i_stim_a,
  input  logic             i_stim_b,
  input  logic             i_dut_y,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_pass_cnt,
  output logic [CNT_W-1:0] o_fail_cnt,
  output logic             o_first_fail_vld,
  output logic [CNT_W-1:0] o_first_fail_idx,
  output logic             o_all_pass
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_VEC - 1);

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_e           r_state;
  op_e              r_op;
  logic [CNT_W-1:0] r_vec_idx;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic [CNT_W-1:0] r_ff_idx;
  logic             r_ff_vld;
  logic             r_busy;
  logic             r_done;

  logic [SLOT_W-1:0] w_slot_in;
  slot_t             w_slot_out;
  logic              w_any_vld;
  logic              w_start_acc;
  logic              w_active;
  logic              w_clr;
  logic              w_push;
  logic              w_cmp;
  logic              w_mis;
  logic              w_abort;
  logic              w_to_done;
  logic              w_to_drain;

  assign w_start_acc = i_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_push      = (r_state == S_RUN) && i_stim_valid;
  assign w_clr       = i_rst || w_start_acc;
  assign w_slot_in   = {w_push, gate_eval(r_op, i_stim_a, i_stim_b), SLOT_IDX_W'(r_vec_idx)};

  // Stage boundary: expectation slots travel DUT_LAT cycles to meet dut_y.
  exp_delay_line #(
    .DEPTH (DUT_LAT)
  ) u_dly (
    .i_clk     (i_clk),
    .i_clr     (w_clr),
    .i_slot    (w_slot_in),
    .o_slot    (w_slot_out),
    .o_any_vld (w_any_vld)
  );

  // Case inequality so an unknown dut_y scores as a mismatch in simulation.
  assign w_cmp = w_active && w_slot_out.vld;
  assign w_mis = w_cmp && (i_dut_y !== w_slot_out.exp);

`ifdef GATE_CHK_ABORT_EN
  assign w_abort = w_mis;
`else
  assign w_abort = 1'b0;
`endif

  assign w_to_done  = w_abort || (r_state == S_DRAIN && !w_any_vld);
  assign w_to_drain = w_push && (r_vec_idx == LAST_IDX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_op       <= OP_AND;
      r_vec_idx  <= '0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_ff_vld   <= 1'b0;
      r_ff_idx   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (w_start_acc) begin
      r_state    <= S_RUN;
      r_op       <= op_e'(i_op);
      r_vec_idx  <= '0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_ff_vld   <= 1'b0;
      r_ff_idx   <= '0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      if (w_cmp) begin
        if (w_mis) begin
          r_fail_cnt <= sat_inc(r_fail_cnt);
          if (!r_ff_vld) begin
            r_ff_vld <= 1'b1;
            r_ff_idx <= CNT_W'(w_slot_out.idx);
          end
        end else begin
          r_pass_cnt <= sat_inc(r_pass_cnt);
        end
      end
      if (w_push) begin
        r_vec_idx <= r_vec_idx + CNT_W'(1);
      end
      if (w_active) begin
        if (w_to_done) begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else if (w_to_drain) begin
          r_state <= S_DRAIN;
        end
      end
    end
  end

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_pass_cnt       = r_pass_cnt;
  assign o_fail_cnt       = r_fail_cnt;
  assign o_first_fail_vld = r_ff_vld;
  assign o_first_fail_idx = r_ff_idx;
  assign o_all_pass       = r_done && (r_fail_cnt == '0);

endmodule

// File: tb/tb_gate_resp_checker.sv
// Directed bench for gate_resp_checker: DUT_LAT=1, 3 and 0 instances share one stimulus bus.
module tb_gate_resp_checker;

  logic       clk = 1'b0;
  logic       rst, start, sv, a, b;
  logic [1:0] op, dut_gate;
  logic       y0, y1, y3;
  logic [2:0] y3_pipe;

  logic       busy1, done1, ffv1, ap1;
  logic [7:0] pass1, fail1, ffi1;
  logic       busy3, done3, ffv3, ap3;
  logic [7:0] pass3, fail3, ffi3;
  logic       busy0, done0, ffv0, ap0;
  logic [1:0] pass0, fail0, ffi0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic tb_gate(logic [1:0] g, logic ia, logic ib);
    case (g)
      2'd0:    return ia & ib;
      2'd1:    return ia | ib;
      2'd2:    return ia ^ ib;
      default: return !(ia & ib);
    endcase
  endfunction

  // Gate DUT models of latency 0, 1 and 3.
  always_comb y0 = tb_gate(dut_gate, a, b);
  always_ff @(posedge clk) begin
    y1      <= tb_gate(dut_gate, a, b);
    y3_pipe <= {y3_pipe[1:0], tb_gate(dut_gate, a, b)};
  end
  assign y3 = y3_pipe[2];

  gate_resp_checker #(.N_VEC(4), .DUT_LAT(1), .CNT_W(8)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_stim_valid(sv),
    .i_stim_a(a), .i_stim_b(b), .i_dut_y(y1), .o_busy(busy1), .o_done(done1),
    .o_pass_cnt(pass1), .o_fail_cnt(fail1), .o_first_fail_vld(ffv1),
    .o_first_fail_idx(ffi1), .o_all_pass(ap1));

  gate_resp_checker #(.N_VEC(4), .DUT_LAT(3), .CNT_W(8)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_stim_valid(sv),
    .i_stim_a(a), .i_stim_b(b), .i_dut_y(y3), .o_busy(busy3), .o_done(done3),
    .o_pass_cnt(pass3), .o_fail_cnt(fail3), .o_first_fail_vld(ffv3),
    .o_first_fail_idx(ffi3), .o_all_pass(ap3));

  gate_resp_checker #(.N_VEC(3), .DUT_LAT(0), .CNT_W(2)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_stim_valid(sv),
    .i_stim_a(a), .i_stim_b(b), .i_dut_y(y0), .o_busy(busy0), .o_done(done0),
    .o_pass_cnt(pass0), .o_fail_cnt(fail0), .o_first_fail_vld(ffv0),
    .o_first_fail_idx(ffi0), .o_all_pass(ap0));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat (6) step();
  endtask

  // Start (with a colliding vector that must be dropped), then vectors 00,01,10,11 back to back.
  task automatic run4(input logic [1:0] op_i, input logic [1:0] g);
    dut_gate = g;
    op       = op_i;
    start    = 1'b1;
    sv       = 1'b1;
    a        = 1'b1;
    b        = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = i[1];
      b = i[0];
      step();
    end
    sv = 1'b0;
  endtask

  task automatic wait_done1(input string tag, output int n);
    n = 0;
    while (!done1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_done"}, int'(done1), 1);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [1:0] gate;
    int         pass_n;
    int         fail_n;
    int         pass_a;
    int         fail_a;
    int         ffv;
    int         ffi;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int n;
    int k;
    logic [6:0] pat;

    // op, DUT gate, pass/fail (full run), pass/fail (abort build), first-fail vld/idx
    tbl[0] = '{2'd0, 2'd0, 4, 0, 4, 0, 0, 0};
    tbl[1] = '{2'd0, 2'd1, 2, 2, 1, 1, 1, 1};
    tbl[2] = '{2'd1, 2'd1, 4, 0, 4, 0, 0, 0};
    tbl[3] = '{2'd2, 2'd2, 4, 0, 4, 0, 0, 0};
    tbl[4] = '{2'd3, 2'd3, 4, 0, 4, 0, 0, 0};
    tbl[5] = '{2'd3, 2'd0, 0, 4, 0, 1, 1, 0};
    tbl[6] = '{2'd2, 2'd1, 3, 1, 3, 1, 1, 3};
    tbl[7] = '{2'd1, 2'd2, 3, 1, 3, 1, 1, 3};

    rst = 1'b1; start = 1'b0; sv = 1'b0; a = 1'b0; b = 1'b0; op = 2'd0; dut_gate = 2'd0;
    repeat (3) step();
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_done1", int'(done1), 0);
    chk("rst_pass1", int'(pass1), 0);
    chk("rst_fail1", int'(fail1), 0);
    chk("rst_ffv1", int'(ffv1), 0);
    chk("rst_ffi1", int'(ffi1), 0);
    chk("rst_ap1", int'(ap1), 0);
    chk("rst_busy3", int'(busy3), 0);
    chk("rst_done0", int'(done0), 0);
    rst = 1'b0;
    step();

    for (int r = 0; r < 8; r++) begin
      run4(tbl[r].op, tbl[r].gate);
      wait_done1($sformatf("tbl%0d", r), n);
`ifdef GATE_CHK_ABORT_EN
      chk($sformatf("tbl%0d_pass", r), int'(pass1), tbl[r].pass_a);
      chk($sformatf("tbl%0d_fail", r), int'(fail1), tbl[r].fail_a);
      chk($sformatf("tbl%0d_allpass", r), int'(ap1), int'(tbl[r].fail_a == 0));
`else
      chk($sformatf("tbl%0d_done_lat", r), n, 1);
      chk($sformatf("tbl%0d_pass", r), int'(pass1), tbl[r].pass_n);
      chk($sformatf("tbl%0d_fail", r), int'(fail1), tbl[r].fail_n);
      chk($sformatf("tbl%0d_allpass", r), int'(ap1), int'(tbl[r].fail_n == 0));
`endif
      chk($sformatf("tbl%0d_ffv", r), int'(ffv1), tbl[r].ffv);
      chk($sformatf("tbl%0d_ffi", r), int'(ffi1), tbl[r].ffi);
      chk($sformatf("tbl%0d_busy", r), int'(busy1), 0);
      gap();
    end

    // AND expected, OR DUT: vector 1 is the first mismatch.
    dut_gate = 2'd1; op = 2'd0; start = 1'b1; sv = 1'b0;
    step();
    start = 1'b0; sv = 1'b1; a = 1'b0; b = 1'b0;
    step();
    a = 1'b0; b = 1'b1;
    step();
    chk("mis_pre_done", int'(done1), 0);
    chk("mis_pre_fail", int'(fail1), 0);
    a = 1'b1; b = 1'b0;
    step();
    chk("mis_v1_fail", int'(fail1), 1);
    chk("mis_v1_pass", int'(pass1), 1);
    chk("mis_v1_ffi", int'(ffi1), 1);
`ifdef GATE_CHK_ABORT_EN
    chk("abort_done", int'(done1), 1);
    chk("abort_busy", int'(busy1), 0);
`else
    chk("noabort_busy", int'(busy1), 1);
`endif
    a = 1'b1; b = 1'b1;
    step();
    sv = 1'b0;
    wait_done1("mis_end", n);
`ifdef GATE_CHK_ABORT_EN
    chk("mis_end_fail", int'(fail1), 1);
`else
    chk("mis_end_fail", int'(fail1), 2);
`endif
    gap();

    // DUT_LAT=3, good XOR DUT, bubbles between pushes.
    dut_gate = 2'd2; op = 2'd2; start = 1'b1; sv = 1'b0;
    step();
    start = 1'b0;
    pat = 7'b1100101;
    k = 0;
    for (int s = 0; s < 7; s++) begin
      sv = pat[s];
      if (pat[s]) begin
        a = k[1];
        b = k[0];
        k++;
      end
      step();
    end
    sv = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("lat3_busy_hold%0d", s), int'(busy3), 1);
      chk($sformatf("lat3_not_done%0d", s), int'(done3), 0);
      step();
    end
    chk("lat3_busy_end", int'(busy3), 0);
    chk("lat3_done", int'(done3), 1);
    chk("lat3_pass", int'(pass3), 4);
    chk("lat3_fail", int'(fail3), 0);
    chk("lat3_allpass", int'(ap3), 1);
    chk("lat3_ffv", int'(ffv3), 0);
    chk("lat3_ffi", int'(ffi3), 0);
    gap();

    // Reset mid-run after two vectors, then a clean rerun.
    dut_gate = 2'd1; op = 2'd0; start = 1'b1; sv = 1'b0;
    step();
    start = 1'b0; sv = 1'b1; a = 1'b0; b = 1'b0;
    step();
    a = 1'b0; b = 1'b1;
    step();
    chk("prerst_pass", int'(pass1), 1);
    chk("prerst_busy", int'(busy1), 1);
    rst = 1'b1; sv = 1'b0;
    step();
    chk("midrst_busy", int'(busy1), 0);
    chk("midrst_done", int'(done1), 0);
    chk("midrst_pass", int'(pass1), 0);
    chk("midrst_fail", int'(fail1), 0);
    chk("midrst_ffv", int'(ffv1), 0);
    chk("midrst_ffi", int'(ffi1), 0);
    chk("midrst_ap", int'(ap1), 0);
    chk("midrst_busy3", int'(busy3), 0);
    rst = 1'b0;
    run4(2'd0, 2'd0);
    wait_done1("postrst", n);
    chk("postrst_pass", int'(pass1), 4);
    chk("postrst_fail", int'(fail1), 0);
    gap();

    // Start during RUN (with a different op) must be ignored.
    dut_gate = 2'd0; op = 2'd0; start = 1'b1; sv = 1'b0;
    step();
    start = 1'b0; sv = 1'b1; a = 1'b0; b = 1'b0;
    step();
    start = 1'b1; op = 2'd3; a = 1'b0; b = 1'b1;
    step();
    start = 1'b0; op = 2'd0; a = 1'b1; b = 1'b0;
    step();
    a = 1'b1; b = 1'b1;
    step();
    sv = 1'b0;
    wait_done1("busy_start", n);
    chk("busy_start_pass", int'(pass1), 4);
    chk("busy_start_fail", int'(fail1), 0);
    // Restart directly from DONE with a faulty DUT.
    run4(2'd0, 2'd1);
    wait_done1("rerun", n);
`ifdef GATE_CHK_ABORT_EN
    chk("rerun_pass", int'(pass1), 1);
    chk("rerun_fail", int'(fail1), 1);
`else
    chk("rerun_pass", int'(pass1), 2);
    chk("rerun_fail", int'(fail1), 2);
`endif
    chk("rerun_ffi", int'(ffi1), 1);
    gap();

    // DUT_LAT=0 instance, N_VEC=3: same-cycle compare, one DRAIN cycle.
    dut_gate = 2'd2; op = 2'd2; start = 1'b1; sv = 1'b1; a = 1'b1; b = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = i[1];
      b = i[0];
      step();
    end
    sv = 1'b0;
    chk("lat0_pass_last", int'(pass0), 3);
    chk("lat0_drain_busy", int'(busy0), 1);
    chk("lat0_drain_done", int'(done0), 0);
    step();
    chk("lat0_done", int'(done0), 1);
    chk("lat0_busy", int'(busy0), 0);
    chk("lat0_allpass", int'(ap0), 1);
    gap();

    dut_gate = 2'd0; op = 2'd3; start = 1'b1; sv = 1'b0;
    step();
    start = 1'b0; sv = 1'b1; a = 1'b0; b = 1'b0;
    step();
    chk("lat0_fail_v0", int'(fail0), 1);
    chk("lat0_ffv", int'(ffv0), 1);
    chk("lat0_ffi", int'(ffi0), 0);
    for (int i = 1; i < 3; i++) begin
      a = i[1];
      b = i[0];
      step();
    end
    sv = 1'b0;
    step();
    chk("lat0_fail_done", int'(done0), 1);
    chk("lat0_fail_pass", int'(pass0), 0);
`ifdef GATE_CHK_ABORT_EN
    chk("lat0_fail_cnt", int'(fail0), 1);
`else
    chk("lat0_fail_cnt", int'(fail0), 3);
`endif
    chk("lat0_fail_ap", int'(ap0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
